// File: rtl/anode_scan_ctrl.sv
// Four-digit seven-segment anode scanner with blanking gaps between digit slots.
// Optional brightness PWM within each dwell when ANODE_SCAN_BRIGHTNESS_PWM_EN is defined.
module anode_scan_ctrl #(
  parameter int unsigned DWELL_CYCLES = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter int unsigned CNT_W        = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] digit_en,
`ifdef ANODE_SCAN_BRIGHTNESS_PWM_EN
  input  logic [3:0] brightness,
`endif
  output logic [3:0] anode,
  output logic [1:0] digit_sel,
  output logic       frame_tick
);

  typedef enum logic [1:0] {StIdle, StBlank, StOn} state_e;

  localparam bit                 HasBlank  = (BLANK_CYCLES != 0);
  localparam logic [CNT_W-1:0]   DwellLast = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0]   BlankLast = CNT_W'(HasBlank ? BLANK_CYCLES - 1 : 0);
  // With no blanking gap, every slot boundary goes straight to the next ON.
  localparam state_e             GapState  = HasBlank ? StBlank : StOn;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       anode_q, anode_d;
  logic             tick_q, tick_d;
  logic             lit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    tick_d  = 1'b0;
    if (!en) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = GapState;
          cnt_d   = '0;
        end
        StBlank: begin
          if (cnt_q == BlankLast) begin
            state_d = StOn;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StOn: begin
          if (cnt_q == DwellLast) begin
            state_d = GapState;
            cnt_d   = '0;
            sel_d   = sel_q + 2'd1;
            tick_d  = (sel_q == 2'd3);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Anode is registered from next-state values so it lines up with the state it belongs to.
  always_comb begin
    lit = (state_d == StOn) && digit_en[sel_d];
`ifdef ANODE_SCAN_BRIGHTNESS_PWM_EN
    lit = lit && (4'(cnt_d) < brightness);
`endif
    anode_d = lit ? ~(4'b0001 << sel_d) : 4'b1111;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sel_q   <= 2'd0;
      anode_q <= 4'b1111;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      anode_q <= anode_d;
      tick_q  <= tick_d;
    end
  end

  assign anode      = anode_q;
  assign digit_sel  = sel_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_anode_scan_ctrl.sv
// Directed bench for anode_scan_ctrl (DWELL=4, BLANK=2; PWM instance when the macro is defined).
module tb_anode_scan_ctrl;

  localparam int Blank = 2;
  localparam int Slot  = 6;
  localparam int Frame = 24;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] digit_en;
  logic [3:0] anode;
  logic [1:0] digit_sel;
  logic       frame_tick;

  int n_cmp  = 0;
  int n_fail = 0;
  int pos;
  bit fresh;

  always #5 clk = ~clk;

`ifdef ANODE_SCAN_BRIGHTNESS_PWM_EN
  logic [3:0] main_bright;
  logic       p_rst_n;
  logic       p_en;
  logic [3:0] p_bright;
  logic [3:0] p_anode;
  logic [1:0] p_sel;
  logic       p_tick;

  anode_scan_ctrl #(.DWELL_CYCLES(32), .BLANK_CYCLES(2), .CNT_W(5)) u_pwm (
    .clk        (clk),
    .rst_n      (p_rst_n),
    .en         (p_en),
    .digit_en   (4'hF),
    .brightness (p_bright),
    .anode      (p_anode),
    .digit_sel  (p_sel),
    .frame_tick (p_tick)
  );
`endif

  anode_scan_ctrl #(.DWELL_CYCLES(4), .BLANK_CYCLES(2), .CNT_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .digit_en   (digit_en),
`ifdef ANODE_SCAN_BRIGHTNESS_PWM_EN
    .brightness (main_bright),
`endif
    .anode      (anode),
    .digit_sel  (digit_sel),
    .frame_tick (frame_tick)
  );

  // Position p counts samples since the scan left IDLE; each slot is 2 blank + 4 lit.
  function automatic logic [3:0] exp_anode(int p, logic [3:0] mask);
    int s;
    int q;
    s = (p % Frame) / Slot;
    q = p % Slot;
    if (q < Blank || !mask[s]) return 4'b1111;
    return ~(4'b0001 << s);
  endfunction

  function automatic logic [1:0] exp_sel(int p);
    return 2'((p % Frame) / Slot);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    en       = 1'b1;
    digit_en = 4'hF;
    repeat (3) step();
    n_cmp++;
    if (anode !== 4'b1111) begin
      n_fail++;
      $display("FAIL reset_anode got %b want 1111", anode);
    end
    n_cmp++;
    if (digit_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_sel got %0d want 0", digit_sel);
    end
    n_cmp++;
    if (frame_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_tick got %b want 0", frame_tick);
    end
    rst_n = 1'b1;
    pos   = 0;
    fresh = 1'b1;
  endtask

  task automatic test_scan();
    logic want_tick;
    for (int i = 0; i < 2 * Frame; i++) begin
      step();
      want_tick = (pos % Frame == 0) && !fresh;
      n_cmp++;
      if (anode !== exp_anode(pos, 4'hF)) begin
        n_fail++;
        $display("FAIL scan_anode pos %0d got %b want %b", pos, anode, exp_anode(pos, 4'hF));
      end
      n_cmp++;
      if (digit_sel !== exp_sel(pos)) begin
        n_fail++;
        $display("FAIL scan_sel pos %0d got %0d want %0d", pos, digit_sel, exp_sel(pos));
      end
      n_cmp++;
      if (frame_tick !== want_tick) begin
        n_fail++;
        $display("FAIL scan_tick pos %0d got %b want %b", pos, frame_tick, want_tick);
      end
      fresh = 1'b0;
      pos++;
    end
  endtask

  task automatic test_mask();
    digit_en = 4'b0101;
    for (int i = 0; i < Frame; i++) begin
      step();
      n_cmp++;
      if (anode !== exp_anode(pos, 4'b0101)) begin
        n_fail++;
        $display("FAIL mask_anode pos %0d got %b want %b", pos, anode, exp_anode(pos, 4'b0101));
      end
      n_cmp++;
      if (frame_tick !== (pos % Frame == 0)) begin
        n_fail++;
        $display("FAIL mask_tick pos %0d got %b want %b", pos, frame_tick, pos % Frame == 0);
      end
      pos++;
    end
    digit_en = 4'hF;
  endtask

  task automatic test_frame();
    int ticks;
    ticks = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (frame_tick === 1'b1) ticks++;
      n_cmp++;
      if (frame_tick !== (pos % Frame == 0)) begin
        n_fail++;
        $display("FAIL frame_tick pos %0d got %b want %b", pos, frame_tick, pos % Frame == 0);
      end
      n_cmp++;
      if (digit_sel !== exp_sel(pos)) begin
        n_fail++;
        $display("FAIL frame_sel pos %0d got %0d want %0d", pos, digit_sel, exp_sel(pos));
      end
      pos++;
    end
    n_cmp++;
    if (ticks != 5) begin
      n_fail++;
      $display("FAIL frame_tick_count got %0d want 5", ticks);
    end
  endtask

  task automatic test_enable_drop();
    logic [3:0] want;
    // Run until the sample just taken is the 2nd lit cycle of digit 2.
    do begin
      step();
      n_cmp++;
      if (anode !== exp_anode(pos, 4'hF)) begin
        n_fail++;
        $display("FAIL drop_pre_anode pos %0d got %b want %b", pos, anode, exp_anode(pos, 4'hF));
      end
      pos++;
    end while (((pos - 1) % Frame) != 15);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (anode !== 4'b1111) begin
        n_fail++;
        $display("FAIL drop_anode cyc %0d got %b want 1111", i, anode);
      end
      n_cmp++;
      if (digit_sel !== 2'd2) begin
        n_fail++;
        $display("FAIL drop_sel cyc %0d got %0d want 2", i, digit_sel);
      end
      n_cmp++;
      if (frame_tick !== 1'b0) begin
        n_fail++;
        $display("FAIL drop_tick cyc %0d got %b want 0", i, frame_tick);
      end
    end
    en = 1'b1;
    for (int i = 0; i < Slot; i++) begin
      step();
      want = (i < Blank) ? 4'b1111 : 4'b1011;
      n_cmp++;
      if (anode !== want) begin
        n_fail++;
        $display("FAIL resume_anode cyc %0d got %b want %b", i, anode, want);
      end
      n_cmp++;
      if (digit_sel !== 2'd2) begin
        n_fail++;
        $display("FAIL resume_sel cyc %0d got %0d want 2", i, digit_sel);
      end
    end
    pos = 18;
  endtask

  task automatic test_reset_mid();
    do begin
      step();
      n_cmp++;
      if (anode !== exp_anode(pos, 4'hF)) begin
        n_fail++;
        $display("FAIL rmid_pre_anode pos %0d got %b want %b", pos, anode, exp_anode(pos, 4'hF));
      end
      n_cmp++;
      if (frame_tick !== (pos % Frame == 0)) begin
        n_fail++;
        $display("FAIL rmid_pre_tick pos %0d got %b want %b", pos, frame_tick, pos % Frame == 0);
      end
      pos++;
    end while (((pos - 1) % Frame) != 9);
    rst_n = 1'b0;
    step();
    n_cmp++;
    if (anode !== 4'b1111) begin
      n_fail++;
      $display("FAIL rmid_anode got %b want 1111", anode);
    end
    n_cmp++;
    if (digit_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL rmid_sel got %0d want 0", digit_sel);
    end
    n_cmp++;
    if (frame_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_tick got %b want 0", frame_tick);
    end
    rst_n = 1'b1;
    pos   = 0;
    for (int i = 0; i < Slot; i++) begin
      step();
      n_cmp++;
      if (anode !== exp_anode(pos, 4'hF)) begin
        n_fail++;
        $display("FAIL rmid_restart pos %0d got %b want %b", pos, anode, exp_anode(pos, 4'hF));
      end
      pos++;
    end
  endtask

`ifdef ANODE_SCAN_BRIGHTNESS_PWM_EN
  task automatic test_pwm();
    int lit;
    logic [3:0] want;
    p_rst_n  = 1'b0;
    p_en     = 1'b0;
    p_bright = 4'd8;
    repeat (2) step();
    p_rst_n = 1'b1;
    p_en    = 1'b1;
    for (int s = 0; s < 4; s++) begin
      lit  = 0;
      want = ~(4'b0001 << s);
      for (int k = 0; k < 34; k++) begin
        step();
        if (p_anode !== 4'b1111) begin
          lit++;
          n_cmp++;
          if (p_anode !== want) begin
            n_fail++;
            $display("FAIL pwm_anode slot %0d got %b want %b", s, p_anode, want);
          end
        end
      end
      n_cmp++;
      if (lit != 16) begin
        n_fail++;
        $display("FAIL pwm_lit slot %0d got %0d want 16", s, lit);
      end
    end
    p_bright = 4'd0;
    lit = 0;
    for (int k = 0; k < 68; k++) begin
      step();
      if (p_anode !== 4'b1111) lit++;
    end
    n_cmp++;
    if (lit != 0) begin
      n_fail++;
      $display("FAIL pwm_dark got %0d lit cycles want 0", lit);
    end
  endtask
`endif

  initial begin
`ifdef ANODE_SCAN_BRIGHTNESS_PWM_EN
    main_bright = 4'd15;
    p_rst_n     = 1'b0;
    p_en        = 1'b0;
    p_bright    = 4'd0;
`endif
    test_reset();
    test_scan();
    test_mask();
    test_frame();
    test_enable_drop();
    test_reset_mid();
`ifdef ANODE_SCAN_BRIGHTNESS_PWM_EN
    test_pwm();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
